bubble_seq_control: RTL
=======================

BUBBLE_SEQ_CONTROL -- requirements
Module: bubble_seq_control

Interface
REQ-001 Parameter N_REG, default 8, meaning number of data registers sorted (legal >= 2).
REQ-002 Parameter SEL_W, default 4, meaning width of register selects; SHALL be >= clog2(N_REG+1).
REQ-003 Parameter ALU_W, default 2, meaning width of ALU opcode.
REQ-004 clk  input  1  meaning single clock; all state updates on rising edge.
REQ-005 rst  input  1  meaning reset; synchronous and active-high.
REQ-006 start  input  1  meaning begin a sort run; sampled only in IDLE.
REQ-007 desc  input  1  meaning 1 = descending order, 0 = ascending; sampled with start and held for the run.
REQ-008 mayor  input  1  meaning datapath compare flag, operand A > operand B (strict), valid in CMP.
REQ-009 o_alu_op  output  ALU_W  meaning 0 NOP, 1 CMP, 2 PASS_A, 3 PASS_B.
REQ-010 o_sel_a, o_sel_b  output  SEL_W each  meaning mux A / mux B register index.
REQ-011 o_sel_reg  output  SEL_W  meaning write-destination index.
REQ-012 o_we  output  1  meaning register-file write enable.
REQ-013 busy  output  1  meaning run in progress.
REQ-014 done  output  1  meaning one-cycle end-of-run pulse.
REQ-015 pass_cnt  output  SEL_W  meaning passes completed in current/last run.

Function
REQ-016 The block SHALL sort registers 0..N_REG-1 by adjacent compare-exchange passes; index N_REG SHALL be the scratch register TMP.
REQ-017 States SHALL be IDLE, SEL, CMP, SWP_T, SWP_A, SWP_B, NEXT, DONE; pair index i SHALL range 0..N_REG-2.
REQ-018 IDLE: start=1 -> SEL with i=0, swap flag cleared, pass_cnt=0, desc latched; otherwise remain.
REQ-019 SEL and CMP SHALL drive o_alu_op=CMP, o_sel_a=i, o_sel_b=i+1 (desc=0) or o_sel_a=i+1, o_sel_b=i (desc=1).
REQ-020 SEL -> CMP unconditionally; CMP -> SWP_T if mayor=1, else NEXT.
REQ-021 SWP_T: o_we=1, o_sel_reg=TMP, o_sel_a=i, o_alu_op=PASS_A.
REQ-022 SWP_A: o_we=1, o_sel_reg=i, o_sel_b=i+1, o_alu_op=PASS_B.
REQ-023 SWP_B: o_we=1, o_sel_reg=i+1, o_sel_a=TMP, o_alu_op=PASS_A; SHALL set swap flag; -> NEXT.
REQ-024 NEXT with i<N_REG-2: i<=i+1, -> SEL.
REQ-025 NEXT with i=N_REG-2: pass_cnt<=pass_cnt+1; if swap flag=1 and pass_cnt+1<N_REG-1 -> SEL with i=0, flag cleared; else -> DONE.
REQ-026 DONE: done=1 for exactly one cycle, -> IDLE; pass_cnt SHALL hold until next start.
REQ-027 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-028 o_we SHALL be 1 only in SWP_T, SWP_A, SWP_B; all unspecified select/opcode outputs SHALL be 0 in each state.
REQ-029 mayor SHALL be ignored outside CMP.
REQ-030 Latency: start sampled at edge 0 -> pair j occupies cycles 3j+1..3j+3 (+3 per swap); no-swap single pass asserts done in cycle 3(N_REG-1)+1.
REQ-031 Pass limit N_REG-1 SHALL terminate the run even if the last pass swapped.

Reset
REQ-032 rst=1 at a rising edge SHALL force IDLE, i=0, swap flag=0, pass_cnt=0, regardless of state (including mid-swap).
REQ-033 During and after reset: o_alu_op=0, o_sel_a=0, o_sel_b=0, o_sel_reg=0, o_we=0, busy=0, done=0.
REQ-034 rst SHALL take priority over start in the same cycle.

Verification
REQ-035 N_REG=4, start pulse, mayor=0 always -> done in cycle 10, o_we never 1, pass_cnt=1.
REQ-036 N_REG=4, behavioural reg model {3,2,1,0}, desc=0 -> final {0,1,2,3}, pass_cnt=3, done once.
REQ-037 N_REG=4, model {0,1,2,3}, desc=1 -> final {3,2,1,0}; first CMP shows o_sel_a=1, o_sel_b=0.
REQ-038 Reset asserted in SWP_A -> next cycle IDLE, all outputs 0, busy=0; new start runs normally.
REQ-039 start held high through run and DONE -> ignored while busy; new run begins only from IDLE, pass_cnt restarts at 0.
REQ-040 mayor=1 on every CMP, N_REG=4 -> exactly 3 passes, 27 writes total, done then IDLE.

Source files
------------

// File: rtl/bubble_seq_control.sv
// Sequencer for an in-place bubble sort over an external register file.
// Each pair is handled by compare, then an optional three-write swap through a scratch register.
module bubble_seq_control #(
    parameter int unsigned N_REG = 8,
    parameter int unsigned SEL_W = 4,
    parameter int unsigned ALU_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             desc,
    input  logic             mayor,
    output logic [ALU_W-1:0] o_alu_op,
    output logic [SEL_W-1:0] o_sel_a,
    output logic [SEL_W-1:0] o_sel_b,
    output logic [SEL_W-1:0] o_sel_reg,
    output logic             o_we,
    output logic             busy,
    output logic             done,
    output logic [SEL_W-1:0] pass_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEL   = 3'd1;
    localparam logic [2:0] S_CMP   = 3'd2;
    localparam logic [2:0] S_SWP_T = 3'd3;
    localparam logic [2:0] S_SWP_A = 3'd4;
    localparam logic [2:0] S_SWP_B = 3'd5;
    localparam logic [2:0] S_NEXT  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [ALU_W-1:0] OP_NOP    = ALU_W'(0);
    localparam logic [ALU_W-1:0] OP_CMP    = ALU_W'(1);
    localparam logic [ALU_W-1:0] OP_PASS_A = ALU_W'(2);
    localparam logic [ALU_W-1:0] OP_PASS_B = ALU_W'(3);

    localparam logic [SEL_W-1:0] TMP_IDX    = SEL_W'(N_REG);
    localparam logic [SEL_W-1:0] LAST_PAIR  = SEL_W'(N_REG - 2);
    localparam logic [SEL_W-1:0] PASS_LIMIT = SEL_W'(N_REG - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] idx_nxt;
    logic             swapped;
    logic             swapped_nxt;
    logic             desc_q;
    logic             desc_nxt;
    logic [SEL_W-1:0] pass_nxt;
    logic [SEL_W-1:0] pass_inc;
    logic [SEL_W-1:0] idx_nxt_p1;

    logic [ALU_W-1:0] alu_op_nxt;
    logic [SEL_W-1:0] sel_a_nxt;
    logic [SEL_W-1:0] sel_b_nxt;
    logic [SEL_W-1:0] sel_reg_nxt;
    logic             we_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    assign pass_inc   = pass_cnt + SEL_W'(1);
    assign idx_nxt_p1 = idx_nxt + SEL_W'(1);

    // Next-state logic plus the Moore outputs of the state being entered,
    // so the registered outputs line up with the state they describe.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        swapped_nxt = swapped;
        desc_nxt    = desc_q;
        pass_nxt    = pass_cnt;
        alu_op_nxt  = OP_NOP;
        sel_a_nxt   = '0;
        sel_b_nxt   = '0;
        sel_reg_nxt = '0;
        we_nxt      = 1'b0;
        busy_nxt    = 1'b1;
        done_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = S_SEL;
                    idx_nxt     = '0;
                    swapped_nxt = 1'b0;
                    pass_nxt    = '0;
                    desc_nxt    = desc;
                end
            end
            S_SEL:   state_nxt = S_CMP;
            S_CMP:   state_nxt = mayor ? S_SWP_T : S_NEXT;
            S_SWP_T: state_nxt = S_SWP_A;
            S_SWP_A: state_nxt = S_SWP_B;
            S_SWP_B: begin
                state_nxt   = S_NEXT;
                swapped_nxt = 1'b1;
            end
            S_NEXT: begin
                if (idx < LAST_PAIR) begin
                    idx_nxt   = idx + SEL_W'(1);
                    state_nxt = S_SEL;
                end else begin
                    pass_nxt = pass_inc;
                    // A clean pass, or hitting the pass limit, ends the run.
                    if (swapped && (pass_inc < PASS_LIMIT)) begin
                        idx_nxt     = '0;
                        swapped_nxt = 1'b0;
                        state_nxt   = S_SEL;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        case (state_nxt)
            S_IDLE: busy_nxt = 1'b0;
            S_SEL, S_CMP: begin
                alu_op_nxt = OP_CMP;
                sel_a_nxt  = desc_nxt ? idx_nxt_p1 : idx_nxt;
                sel_b_nxt  = desc_nxt ? idx_nxt : idx_nxt_p1;
            end
            S_SWP_T: begin
                we_nxt      = 1'b1;
                sel_reg_nxt = TMP_IDX;
                sel_a_nxt   = idx_nxt;
                alu_op_nxt  = OP_PASS_A;
            end
            S_SWP_A: begin
                we_nxt      = 1'b1;
                sel_reg_nxt = idx_nxt;
                sel_b_nxt   = idx_nxt_p1;
                alu_op_nxt  = OP_PASS_B;
            end
            S_SWP_B: begin
                we_nxt      = 1'b1;
                sel_reg_nxt = idx_nxt_p1;
                sel_a_nxt   = TMP_IDX;
                alu_op_nxt  = OP_PASS_A;
            end
            S_DONE:  done_nxt = 1'b1;
            default: ;
        endcase
    end

    // State and registered outputs; reset wins over any in-flight swap or start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            swapped   <= 1'b0;
            desc_q    <= 1'b0;
            pass_cnt  <= '0;
            o_alu_op  <= OP_NOP;
            o_sel_a   <= '0;
            o_sel_b   <= '0;
            o_sel_reg <= '0;
            o_we      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            swapped   <= swapped_nxt;
            desc_q    <= desc_nxt;
            pass_cnt  <= pass_nxt;
            o_alu_op  <= alu_op_nxt;
            o_sel_a   <= sel_a_nxt;
            o_sel_b   <= sel_b_nxt;
            o_sel_reg <= sel_reg_nxt;
            o_we      <= we_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule
